// File: rtl/image_frame_loader.sv
// Captures an 8x8 binary image one row per cycle, signals the convolution stage when a
// frame is complete, and serves zero-padded pixel reads while the frame is held.
module image_frame_loader #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned CW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [COLS-1:0]      in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 frame_abort,
  input  logic                 proc_done,
  input  logic signed [CW-1:0] rd_x,
  input  logic signed [CW-1:0] rd_y,
  output logic                 rd_pixel,
  output logic                 start_processing,
  output logic                 frame_loaded,
  output logic [3:0]           row_count
);

  localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {StLoad, StStart, StHold} state_e;

  state_e                   state;
  logic [ROWS-1:0][COLS-1:0] frame;
  logic                     accept;
  logic                     x_in, y_in;

  // ena gates readiness so a disabled loader never appears to take a row
  assign in_ready         = ena && !reset && (state == StLoad);
  assign accept           = in_ready && in_valid && !frame_abort;
  assign start_processing = ena && (state == StStart);
  assign frame_loaded     = (state != StLoad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StLoad;
      row_count <= '0;
      frame     <= '0;
    end else if (ena) begin
      unique case (state)
        StLoad: begin
          if (frame_abort) begin
            row_count <= '0;
          end else if (accept) begin
            frame[row_count[YW-1:0]] <= in_data;
            row_count                <= row_count + 4'd1;
            if (row_count == 4'(ROWS - 1)) state <= StStart;
          end
        end
        StStart: state <= StHold;
        StHold: begin
          if (proc_done) begin
            row_count <= '0;
            state     <= StLoad;
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

  // Sign bit set means negative coordinate, which pads to zero
  assign x_in = !rd_x[CW-1] && (rd_x < CW'(COLS));
  assign y_in = !rd_y[CW-1] && (rd_y < CW'(ROWS));

  always_comb begin
    rd_pixel = 1'b0;
    if (x_in && y_in) rd_pixel = frame[rd_y[YW-1:0]][rd_x[XW-1:0]];
  end

endmodule

// File: tb/tb_image_frame_loader.sv
// Directed bench for image_frame_loader: start pulses are checked by a scoreboard monitor,
// levels and pixel reads are checked directly against hand-computed values.
module tb_image_frame_loader;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset, ena, in_valid, frame_abort, proc_done;
  logic [7:0]    in_data;
  logic [CW-1:0] rd_x, rd_y;
  logic          in_ready, rd_pixel, start_processing, frame_loaded;
  logic [3:0]    row_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_start_q[$];

  image_frame_loader #(.ROWS(8), .COLS(8), .CW(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .ena              (ena),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .frame_abort      (frame_abort),
    .proc_done        (proc_done),
    .rd_x             (rd_x),
    .rd_y             (rd_y),
    .rd_pixel         (rd_pixel),
    .start_processing (start_processing),
    .frame_loaded     (frame_loaded),
    .row_count        (row_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every observed start pulse must match the next expected cycle
  always @(negedge clk) begin
    if (start_processing) begin
      checks++;
      if (exp_start_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_start_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL start_cycle: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input int x, input int y, input int exp);
    rd_x = x[CW-1:0];
    rd_y = y[CW-1:0];
    #1;
    chk($sformatf("rd(%0d,%0d)", x, y), int'(rd_pixel), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ena = 1'b1; in_valid = 1'b0; frame_abort = 1'b0; proc_done = 1'b0;
    in_data = 8'h00; rd_x = '0; rd_y = '0;
    step();
    chk("ready_in_reset", int'(in_ready), 0);
    step();
    reset = 1'b0;
    #1;
    chk("reset_row_count", int'(row_count), 0);
    chk("reset_loaded", int'(frame_loaded), 0);
    chk("reset_start", int'(start_processing), 0);
    chk("ready_after_reset", int'(in_ready), 1);

    // Diagonal frame: row y = 1<<y
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(1 << i);
      step();
      chk($sformatf("diag_row_count_%0d", i), int'(row_count), i + 1);
      if (i == 7) exp_start_q.push_back(cyc);
    end
    in_valid = 1'b0;
    chk("diag_loaded", int'(frame_loaded), 1);
    chk("diag_ready_start", int'(in_ready), 0);
    step();
    step();
    check_rd(3, 3, 1);
    check_rd(3, 4, 0);
    check_rd(-1, 0, 0);
    check_rd(8, 7, 0);
    check_rd(0, -1, 0);
    check_rd(7, 8, 0);
    check_rd(7, 7, 1);
    check_rd(0, 0, 1);
    check_rd(-16, -16, 0);

    // HOLD ignores incoming bytes
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready", int'(in_ready), 0);
      step();
    end
    chk("hold_row_count", int'(row_count), 8);
    check_rd(0, 0, 1);
    check_rd(1, 0, 0);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;
    in_valid  = 1'b0;
    chk("done_loaded", int'(frame_loaded), 0);
    chk("done_ready", int'(in_ready), 1);
    chk("done_row_count", int'(row_count), 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("after_done_row_count", int'(row_count), 1);
    check_rd(1, 0, 1);
    check_rd(0, 0, 0);

    // Abort handling
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    chk("abort_clear", int'(row_count), 0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 3; i++) step();
    chk("ff_row_count", int'(row_count), 3);
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    chk("abort_drop", int'(row_count), 0);
    in_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 7) exp_start_q.push_back(cyc);
    end
    in_valid = 1'b0;
    chk("zero_row_count", int'(row_count), 8);
    step();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) check_rd(x, y, 0);
    proc_done = 1'b1;
    step();
    proc_done = 1'b0;

    // ena low mid-load and in START
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i + 1);
      step();
    end
    chk("ena_pre_count", int'(row_count), 5);
    ena     = 1'b0;
    in_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ena_low_ready", int'(in_ready), 0);
      step();
    end
    chk("ena_low_count", int'(row_count), 5);
    ena = 1'b1;
    for (int i = 5; i < 8; i++) begin
      in_data = 8'(i + 1);
      step();
    end
    in_valid = 1'b0;
    ena      = 1'b0;
    #1;
    chk("deferred_start_low", int'(start_processing), 0);
    step();
    step();
    step();
    chk("deferred_loaded", int'(frame_loaded), 1);
    exp_start_q.push_back(cyc);
    ena = 1'b1;
    #1;
    chk("deferred_start_high", int'(start_processing), 1);
    step();
    step();
    check_rd(0, 0, 1);
    check_rd(2, 4, 1);
    check_rd(1, 4, 0);
    check_rd(3, 7, 1);
    check_rd(0, 7, 0);
    chk("ena_row_count", int'(row_count), 8);

    // Reset while holding a frame
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_hold_row_count", int'(row_count), 0);
    chk("rst_hold_loaded", int'(frame_loaded), 0);
    chk("rst_hold_start", int'(start_processing), 0);
    chk("rst_hold_ready", int'(in_ready), 1);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) check_rd(x, y, 0);
    for (int i = 0; i < 4; i++) step();

    while (exp_start_q.size() != 0) begin
      int e;
      e = exp_start_q.pop_front();
      checks++;
      errors++;
      $display("FAIL start_missing: no pulse seen, expected cycle %0d", e);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Receives an 8x8 binary image one row per byte and assembles it into a 64-bit frame buffer.
- Once a full frame is captured, issues the start pulse to the convolution stage.
- Gives the convolution stage a zero-padded (x, y) pixel read port and holds the frame stable until processing completes.
- Sits between the top-level ui_in pins and conv2d_layer; it fills the "load image" slot of the top level.

Parameters:
- ROWS, 8, number of image rows (bytes per frame)
- COLS, 8, pixels per row; must equal the byte width of in_data
- CW, 5, width of the signed read coordinates

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ena  input  1  design enable; when low, all state holds and no pulses are issued
- in_data  input  8  one image row; bit x is pixel (x, row)
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader accepts a row this cycle
- frame_abort  input  1  discard the partial frame and restart loading at row 0
- proc_done  input  1  consumer has finished with the frame (1-cycle pulse)
- rd_x  input  CW  signed pixel column
- rd_y  input  CW  signed pixel row
- rd_pixel  output  1  pixel at (rd_x, rd_y); 0 outside the image
- start_processing  output  1  1-cycle pulse: frame is complete and stable
- frame_loaded  output  1  level: buffer holds a complete frame
- row_count  output  4  rows accepted in the current frame, 0..ROWS

Behaviour:
- States:
  - LOAD (reset state)
  - START
  - HOLD
- Reset, on a synchronous clk edge with reset=1:
  - state=LOAD, row_count=0, frame buffer all 0
  - in_ready=0 during reset; in_ready=1 from the first cycle after reset
  - start_processing=0, frame_loaded=0
- ena=0: no state, counter, or buffer change; start_processing forced 0; in_ready=0.
- LOAD:
  - in_ready=1.
  - Accept occurs on a cycle with ena && in_valid && in_ready.
  - On accept: row[row_count] <= in_data; row_count increments.
  - On the accept of row ROWS-1: row_count becomes ROWS and state goes to START the next cycle.
- START:
  - start_processing=1 for exactly this one cycle; frame_loaded=1.
  - in_ready=0.
  - Unconditionally moves to HOLD.
- HOLD:
  - frame_loaded=1, in_ready=0; the buffer is frozen.
  - On proc_done: row_count<=0, frame_loaded<=0, state<=LOAD.
  - in_ready=1 on the cycle after proc_done.
- Mode/event interactions:
  - proc_done in LOAD or START is ignored.
  - Same-cycle proc_done and in_valid in HOLD: the byte is not accepted, because in_ready=0.
- frame_abort:
  - In LOAD: row_count<=0. Already-written rows keep their data but will be overwritten.
  - frame_abort has priority over a same-cycle accept; that byte is dropped.
  - In START or HOLD: ignored. The consumer owns the frame.
- Read port:
  - Purely combinational.
  - rd_pixel = row[rd_y][rd_x] when 0<=rd_x<COLS and 0<=rd_y<ROWS; otherwise 0.
  - Coordinates are two's complement; negative values pad to 0.
  - Valid in every state. During LOAD it returns the current mix of new and old rows; the consumer reads only after start_processing.
- Back-to-back frames: after proc_done, the first row can be accepted one cycle later. Peak throughput is one row per cycle.
- Reset mid-frame, in any state: returns to LOAD with the buffer cleared. A start pulse already issued is not repeated.

Test Plan:
- Reset, then 8 consecutive valid bytes 0x01,0x02,...,0x80 → row_count 1..8; start_processing high for exactly 1 cycle, 1 cycle after the 8th accept; frame_loaded=1; rd_pixel(3,3)=1, rd_pixel(3,4)=0.
- Zero-padding reads on the frame above → rd_pixel(-1,0)=0, (8,7)=0, (0,-1)=0, (7,8)=0, (7,7)=1, (0,0)=1.
- Load 3 rows of 0xFF, assert frame_abort in the same cycle as a 4th valid byte, then load 8 rows of 0x00 → start fires only after the 8 new rows; all in-range reads return 0.
- In HOLD, drive in_valid with 0xAA for 5 cycles → in_ready=0, buffer unchanged; pulse proc_done → frame_loaded=0 next cycle, in_ready=1; the next byte lands in row 0.
- Drop ena for 4 cycles mid-load, at row_count=5, with in_valid=1 → row_count stays 5, no accept; loading resumes when ena returns. Also hold ena=0 in START → the pulse is deferred, not lost.
- Assert reset in HOLD → the next cycle has state LOAD, row_count=0, all reads 0, start_processing=0.
